// File: rtl/ftq_queue_pkg.sv
// Shared configuration types and pointer helpers for the fetch target queue.
// Combinational helpers only; no state; no flow control.
// Live-range test works on pointers zero-extended to 32 bits with wrap modulo 2^w.
package ftq_queue_pkg;

    typedef struct packed {
        logic [31:0] VLEN;
        logic [31:0] FTQ_DEPTH;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{VLEN: 32'd32, FTQ_DEPTH: 32'd8};

    // True when p lies in the half-open circular window [c, e) of a w-bit pointer space.
    function automatic logic ptr_in_range(input logic [31:0] p,
                                          input logic [31:0] c,
                                          input logic [31:0] e,
                                          input int unsigned w);
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        return ((p - c) & mask) < ((e - c) & mask);
    endfunction

endpackage

// File: rtl/ftq_ptr.sv
// Circular queue pointer with wrap bit: increment by one or load a new value.
// Registered output, zero cycles from control to next-state.
// Load has priority over increment; no backpressure of its own.
module ftq_ptr #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] ptr_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_o <= '0;
        end else if (load_i) begin
            ptr_o <= load_val_i;
        end else if (inc_i) begin
            ptr_o <= ptr_o + 1'b1;
        end
    end

endmodule

// File: rtl/ftq_queue.sv
// Fetch target queue: BPU enqueues fetch blocks, IFU fetches them, backend commits/redirects.
// Enqueue visible to IFU one cycle later (no bypass); IFU outputs read combinationally.
// bpu_ready_o = !full_o, independent of commit_i. Optional FTQ_PERF_EN adds stall_cnt_o.
module ftq_queue
    import ftq_queue_pkg::*;
#(
    parameter cfg_t Cfg = EmptyCfg,
    localparam int unsigned IdxW = $clog2(Cfg.FTQ_DEPTH),
    localparam int unsigned PtrW = IdxW + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                bpu_valid_i,
    output logic                bpu_ready_o,
    input  logic [Cfg.VLEN-1:0] bpu_pc_i,
    input  logic                bpu_taken_i,
    input  logic [Cfg.VLEN-1:0] bpu_target_i,
    output logic [IdxW-1:0]     bpu_idx_o,
    output logic                ifu_valid_o,
    input  logic                ifu_ready_i,
    output logic [Cfg.VLEN-1:0] ifu_pc_o,
    output logic                ifu_taken_o,
    output logic [Cfg.VLEN-1:0] ifu_target_o,
    output logic [IdxW-1:0]     ifu_idx_o,
    input  logic                commit_i,
    input  logic                redirect_i,
    input  logic [IdxW-1:0]     redirect_idx_i,
    output logic                full_o,
    output logic                empty_o
`ifdef FTQ_PERF_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);

    typedef logic [IdxW-1:0] ftq_idx_t;
    typedef logic [PtrW-1:0] ftq_ptr_t;

    typedef struct packed {
        logic [Cfg.VLEN-1:0] pc;
        logic                taken;
        logic [Cfg.VLEN-1:0] target;
    } ftq_entry_t;

    ftq_entry_t mem [0:(1 << IdxW) - 1];

    ftq_ptr_t enq_ptr, fetch_ptr, commit_ptr;
    ftq_ptr_t redir_ptr, redir_next;
    ftq_idx_t enq_idx, fetch_idx, commit_idx;
    logic     enq_fire, fetch_fire;
    logic     redir_wrap;

    assign enq_idx    = enq_ptr[IdxW-1:0];
    assign fetch_idx  = fetch_ptr[IdxW-1:0];
    assign commit_idx = commit_ptr[IdxW-1:0];

    assign full_o      = (enq_idx == commit_idx) && (enq_ptr[PtrW-1] != commit_ptr[PtrW-1]);
    assign empty_o     = (enq_ptr == commit_ptr);
    assign bpu_ready_o = !full_o;
    assign ifu_valid_o = (fetch_ptr != enq_ptr);
    assign bpu_idx_o   = enq_idx;
    assign ifu_idx_o   = fetch_idx;

    assign enq_fire   = bpu_valid_i && bpu_ready_o && !redirect_i;
    assign fetch_fire = ifu_valid_o && ifu_ready_i && !redirect_i;

    // Indices at or above the commit index belong to the commit lap; below it, to the next lap.
    assign redir_wrap = (redirect_idx_i >= commit_idx) ? commit_ptr[PtrW-1] : ~commit_ptr[PtrW-1];
    assign redir_ptr  = {redir_wrap, redirect_idx_i};
    assign redir_next = redir_ptr + 1'b1;

    ftq_ptr #(.W(PtrW)) u_enq_ptr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (enq_fire),
        .load_i     (redirect_i),
        .load_val_i (redir_next),
        .ptr_o      (enq_ptr)
    );

    ftq_ptr #(.W(PtrW)) u_fetch_ptr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (fetch_fire),
        .load_i     (redirect_i),
        .load_val_i (redir_next),
        .ptr_o      (fetch_ptr)
    );

    ftq_ptr #(.W(PtrW)) u_commit_ptr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (commit_i),
        .load_i     (1'b0),
        .load_val_i ('0),
        .ptr_o      (commit_ptr)
    );

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem[enq_idx] <= '{pc: bpu_pc_i, taken: bpu_taken_i, target: bpu_target_i};
        end
    end

    assign ifu_pc_o     = mem[fetch_idx].pc;
    assign ifu_taken_o  = mem[fetch_idx].taken;
    assign ifu_target_o = mem[fetch_idx].target;

`ifdef FTQ_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (redirect_i) begin
            stall_cnt_o <= '0;
        end else if (bpu_valid_i && full_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

    a_commit_fetched: assert property (@(posedge clk_i) disable iff (rst_i)
        commit_i |-> (commit_ptr != fetch_ptr));

    a_redirect_live: assert property (@(posedge clk_i) disable iff (rst_i)
        redirect_i |-> ptr_in_range(32'(redir_ptr), 32'(commit_ptr), 32'(enq_ptr), PtrW));

endmodule

// File: tb/tb_ftq_queue.sv
// Directed bench for ftq_queue (depth 8, VLEN 32) with a scoreboard on the IFU port.
module tb_ftq_queue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        bpu_valid_i = 1'b0;
    logic        bpu_ready_o;
    logic [31:0] bpu_pc_i = '0;
    logic        bpu_taken_i = 1'b0;
    logic [31:0] bpu_target_i = '0;
    logic [2:0]  bpu_idx_o;
    logic        ifu_valid_o;
    logic        ifu_ready_i = 1'b0;
    logic [31:0] ifu_pc_o;
    logic        ifu_taken_o;
    logic [31:0] ifu_target_o;
    logic [2:0]  ifu_idx_o;
    logic        commit_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [2:0]  redirect_idx_i = '0;
    logic        full_o;
    logic        empty_o;
`ifdef FTQ_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    ftq_queue dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .bpu_valid_i    (bpu_valid_i),
        .bpu_ready_o    (bpu_ready_o),
        .bpu_pc_i       (bpu_pc_i),
        .bpu_taken_i    (bpu_taken_i),
        .bpu_target_i   (bpu_target_i),
        .bpu_idx_o      (bpu_idx_o),
        .ifu_valid_o    (ifu_valid_o),
        .ifu_ready_i    (ifu_ready_i),
        .ifu_pc_o       (ifu_pc_o),
        .ifu_taken_o    (ifu_taken_o),
        .ifu_target_o   (ifu_target_o),
        .ifu_idx_o      (ifu_idx_o),
        .commit_i       (commit_i),
        .redirect_i     (redirect_i),
        .redirect_idx_i (redirect_idx_i),
        .full_o         (full_o),
        .empty_o        (empty_o)
`ifdef FTQ_PERF_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [2:0]  idx;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [2:0] m_idx = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bpu_valid_i = 1'b0;
        ifu_ready_i = 1'b0;
        commit_i = 1'b0;
        redirect_i = 1'b0;
        tick();
        tick();
        exp_q.delete();
        m_idx = '0;
        rst_i = 1'b0;
        #1;
    endtask

    task automatic enq(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        chk("enq_ready", 64'(bpu_ready_o), 64'd1);
        bpu_valid_i  = 1'b1;
        bpu_pc_i     = pc;
        bpu_taken_i  = taken;
        bpu_target_i = target;
        exp_q.push_back('{pc: pc, taken: taken, target: target, idx: m_idx});
        m_idx = m_idx + 3'd1;
        tick();
        bpu_valid_i = 1'b0;
    endtask

    task automatic fetch_n(input int n);
        ifu_ready_i = 1'b1;
        repeat (n) tick();
        ifu_ready_i = 1'b0;
    endtask

    task automatic commit_n(input int n);
        commit_i = 1'b1;
        repeat (n) tick();
        commit_i = 1'b0;
    endtask

    task automatic redirect(input logic [2:0] idx);
        redirect_i = 1'b1;
        redirect_idx_i = idx;
        exp_q.delete();
        m_idx = idx + 3'd1;
        tick();
        redirect_i = 1'b0;
    endtask

    // Scoreboard monitor: every IFU handshake pops and checks the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && ifu_valid_o && ifu_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("ifu_unexpected_fetch", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ifu_pc", 64'(ifu_pc_o), 64'(e.pc));
                    chk("ifu_taken", 64'(ifu_taken_o), 64'(e.taken));
                    chk("ifu_target", 64'(ifu_target_o), 64'(e.target));
                    chk("ifu_idx", 64'(ifu_idx_o), 64'(e.idx));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_ready", 64'(bpu_ready_o), 64'd1);
        chk("rst_ifu_valid", 64'(ifu_valid_o), 64'd0);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_bpu_idx", 64'(bpu_idx_o), 64'd0);
        chk("rst_ifu_idx", 64'(ifu_idx_o), 64'd0);

        // Single enqueue, visible next cycle
        enq(32'h8000_0000, 1'b1, 32'h8000_0040);
        chk("one_ifu_valid", 64'(ifu_valid_o), 64'd1);
        chk("one_ifu_idx", 64'(ifu_idx_o), 64'd0);
        chk("one_empty", 64'(empty_o), 64'd0);
        fetch_n(1);
        chk("one_drained", 64'(ifu_valid_o), 64'd0);

        // Fill to full, free one, wrap
        do_reset();
        for (int i = 0; i < 8; i++)
            enq(32'h1000 + 32'(i) * 32'h20, 1'(i), 32'h1100 + 32'(i) * 32'h20);
        chk("full_full", 64'(full_o), 64'd1);
        chk("full_ready", 64'(bpu_ready_o), 64'd0);
        chk("full_bpu_idx", 64'(bpu_idx_o), 64'd0);
        fetch_n(1);
        commit_i = 1'b1;
        #1;
        chk("full_ready_same_cycle", 64'(bpu_ready_o), 64'd0);
        tick();
        commit_i = 1'b0;
        chk("full_ready_after_commit", 64'(bpu_ready_o), 64'd1);
        chk("full_cleared", 64'(full_o), 64'd0);
        chk("ninth_bpu_idx", 64'(bpu_idx_o), 64'd0);
        enq(32'h2000, 1'b0, 32'h2100);
        chk("ninth_full_again", 64'(full_o), 64'd1);
        fetch_n(8);
        chk("wrap_drained", 64'(ifu_valid_o), 64'd0);
        chk("wrap_not_empty", 64'(empty_o), 64'd0);

        // Redirect rollback
        do_reset();
        for (int i = 0; i < 5; i++)
            enq(32'h3000 + 32'(i) * 32'h10, 1'b0, 32'h0);
        fetch_n(4);
        redirect(3'd1);
        chk("redir_ifu_valid", 64'(ifu_valid_o), 64'd0);
        chk("redir_bpu_idx", 64'(bpu_idx_o), 64'd2);
        chk("redir_ifu_idx", 64'(ifu_idx_o), 64'd2);
        enq(32'h4000, 1'b1, 32'h4444);
        fetch_n(1);
        bpu_valid_i = 1'b1;
        bpu_pc_i = 32'hDEAD_0000;
        redirect(3'd2);
        chk("redir_drop_bpu_idx", 64'(bpu_idx_o), 64'd3);
        chk("redir_drop_ifu_valid", 64'(ifu_valid_o), 64'd0);

        // Simultaneous enqueue + fetch + commit
        do_reset();
        enq(32'h5000, 1'b0, 32'h5100);
        enq(32'h5020, 1'b1, 32'h5120);
        enq(32'h5040, 1'b0, 32'h5140);
        fetch_n(1);
        bpu_valid_i = 1'b1;
        bpu_pc_i = 32'h5060;
        bpu_taken_i = 1'b1;
        bpu_target_i = 32'h5160;
        exp_q.push_back('{pc: 32'h5060, taken: 1'b1, target: 32'h5160, idx: 3'd3});
        ifu_ready_i = 1'b1;
        commit_i = 1'b1;
        tick();
        bpu_valid_i = 1'b0;
        ifu_ready_i = 1'b0;
        commit_i = 1'b0;
        chk("sim_bpu_idx", 64'(bpu_idx_o), 64'd4);
        chk("sim_ifu_idx", 64'(ifu_idx_o), 64'd2);
        chk("sim_ifu_valid", 64'(ifu_valid_o), 64'd1);
        chk("sim_not_empty", 64'(empty_o), 64'd0);
        fetch_n(2);
        commit_n(3);
        chk("sim_empty", 64'(empty_o), 64'd1);

`ifdef FTQ_PERF_EN
        do_reset();
        for (int i = 0; i < 8; i++)
            enq(32'h6000 + 32'(i), 1'b0, 32'h0);
        bpu_valid_i = 1'b1;
        repeat (10) tick();
        bpu_valid_i = 1'b0;
        chk("perf_stall_10", 64'(stall_cnt_o), 64'd10);
        redirect(3'd7);
        chk("perf_stall_clear", 64'(stall_cnt_o), 64'd0);
`endif

        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ftq_queue.md
Name: ftq_queue

Overview:
- Fetch target queue between the branch predictor (producer) and the ICache/IFU fetch path (consumer); backend commit is a third agent.
- Each entry is one fetch block: start PC plus predicted-taken flag and target.
- Three circular pointers: enqueue (BPU writes), fetch (IFU reads) and commit (backend frees).
- Backend redirect rolls the enqueue and fetch pointers back to just past a given entry.

Parameters:
- Cfg, config_pkg::EmptyCfg (top supplies the real cfg_t), global configuration; uses Cfg.VLEN and Cfg.FTQ_DEPTH (power of two, >=2).
- IdxW, $clog2(Cfg.FTQ_DEPTH), entry index width (localparam).
- PtrW, IdxW+1, pointer width including wrap bit (localparam).

Ports:
- clk_i in 1 clock
- rst_i in 1 asynchronous active-high reset
- bpu_valid_i in 1 BPU offers a fetch block
- bpu_ready_o out 1 FTQ can accept
- bpu_pc_i in Cfg.VLEN fetch block start PC
- bpu_taken_i in 1 predicted taken
- bpu_target_i in Cfg.VLEN predicted target
- bpu_idx_o out IdxW index the offered block is written to (equals enq_ptr index)
- ifu_valid_o out 1 entry available for fetch
- ifu_ready_i in 1 IFU consumes entry
- ifu_pc_o out Cfg.VLEN start PC of fetch-pointer entry
- ifu_taken_o out 1 predicted taken
- ifu_target_o out Cfg.VLEN predicted target
- ifu_idx_o out IdxW fetch-pointer index
- commit_i in 1 free oldest entry
- redirect_i in 1 backend redirect
- redirect_idx_i in IdxW ftq index of mispredicted block (kept)
- full_o out 1 queue full
- empty_o out 1 no uncommitted entries

Behaviour:
- Reset (async, rst_i=1): enq_ptr, fetch_ptr and commit_ptr = 0. bpu_ready_o=1, ifu_valid_o=0, full_o=0, empty_o=1, index outputs 0. Entry storage is not reset; data outputs are don't-care while ifu_valid_o=0.
- Pointers: PtrW bits, MSB is the wrap bit, increment mod 2^PtrW.
- full when enq and commit indices are equal and the wrap bits differ. empty when enq_ptr == commit_ptr.
- Enqueue fires on bpu_valid_i && bpu_ready_o, with bpu_ready_o = !full_o.
  - The entry at enq index is written at the clock edge; enq_ptr advances by 1.
  - The entry is visible to the IFU the next cycle (1-cycle latency); there is no bypass.
- Fetch:
  - ifu_valid_o = (fetch_ptr != enq_ptr).
  - Outputs are read combinationally from the entry at the fetch index.
  - Fires on ifu_valid_o && ifu_ready_i; fetch_ptr advances by 1.
- Commit:
  - commit_i frees the entry at commit_ptr; commit_ptr advances by 1.
  - commit_i while commit_ptr == fetch_ptr is illegal (assertion).
  - Freeing from full allows an enqueue the next cycle. Same-cycle enqueue is not permitted, because ready does not depend on commit_i.
- Redirect:
  - Highest priority. enq_ptr and fetch_ptr both become P+1, where P is the pointer with index redirect_idx_i and wrap bit chosen so that P lies in [commit_ptr, enq_ptr).
  - Any enqueue or fetch fire in the same cycle is discarded.
  - A simultaneous commit_i still advances commit_ptr.
  - A redirect_idx_i outside the live range is illegal (assertion).
- Simultaneous enqueue + fetch + commit in one cycle: each pointer updates independently.
- Wrap-around: DEPTH consecutive enqueues with no commit -> full_o=1 and bpu_ready_o=0. Indices wrap 7->0 for depth 8.
- Reset mid-operation: all pointers return to 0 immediately. In-flight handshakes are lost.

Optional Feature:
- Macro FTQ_PERF_EN.
- Defined:
  - Extra output port stall_cnt_o (32 bit).
  - Counts cycles with bpu_valid_i && full_o and saturates at 2^32-1.
  - Resets to 0 with rst_i, and also clears on redirect_i.
- Undefined: the port and counter are absent. No other behaviour changes.

Decomposition:
- Add to config_pkg / a shared ftq_pkg:
  - ftq_entry_t packed struct {pc, taken, target} parameterized via Cfg.VLEN (or as width localparams).
  - Typedefs for ftq_idx_t and ftq_ptr_t.
  - Helper function ptr_in_range().
- One natural sub-module: ftq_ptr (pointer register with wrap bit, increment and load), instantiated three times.

Test Plan:
- Reset then idle -> empty_o=1, bpu_ready_o=1, ifu_valid_o=0, all idx=0.
- Enqueue pc=0x8000_0000 taken=1 target=0x8000_0040 -> the next cycle ifu_valid_o=1, ifu_pc_o=0x8000_0000, ifu_target_o=0x8000_0040, ifu_idx_o=0.
- Depth 8: 8 enqueues, no commit -> full_o=1, bpu_ready_o=0. One fetch + one commit -> bpu_ready_o=1 the next cycle. The ninth enqueue lands at idx 0 with wrap bit 1.
- Enqueue 5, fetch 4, then redirect_idx_i=1 -> enq_ptr=fetch_ptr=2, ifu_valid_o=0. The next enqueue lands at idx 2.
- Same cycle: enqueue, fetch and commit with 3 live entries -> live count stays 3 and all pointers advance by 1. Same cycle: redirect + enqueue -> the enqueue is dropped.
- FTQ_PERF_EN: hold bpu_valid_i 10 cycles while full -> stall_cnt_o=10. Redirect -> 0.
